mas_alu_top: RTL and testbench

Multi-cycle integer ALU for the MAS datapath. On each request it performs one of four operations (add, subtract, right shift, left shift) on two `MAS_BLEN`-bit operands. It registers the result and raises a ready indication when the result is valid. It is the leaf arithmetic block the MAS command sequencer issues `type_mas_alu_cmd` operations to.

---
 rtl/mas_alu_pkg.sv | 22 ++
 rtl/mas_alu_fsm.sv | 45 ++++
 rtl/mas_alu_top.sv | 114 +++++++++++
 tb/tb_mas_alu_top.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mas_alu_pkg.sv
// mas_alu_pkg: shared types and constants for the MAS integer ALU.
//   MAS_ALU_BLEN_DEFAULT : default operand/result width (power of two, >= 8)
//   type_mas_alu_cmd     : operation select driven by the MAS command sequencer
//   mas_alu_fsm_state_t  : control FSM state encoding (exposed by mas_alu_fsm)
package mas_alu_pkg;

  localparam int MAS_ALU_BLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    MAS_ALU_ADD    = 2'd0,
    MAS_ALU_SUB    = 2'd1,
    MAS_ALU_RSHIFT = 2'd2,
    MAS_ALU_LSHIFT = 2'd3
  } type_mas_alu_cmd;

  typedef enum logic [1:0] {
    MAS_ALU_FSM_IDLE = 2'd0,
    MAS_ALU_FSM_OPER = 2'd1,
    MAS_ALU_FSM_DONE = 2'd2
  } mas_alu_fsm_state_t;

endpackage

// File: rtl/mas_alu_fsm.sv
// mas_alu_fsm: request sequencer for the MAS ALU.
//   IDLE -> OPER on req; OPER -> DONE always; DONE -> OPER on req, else IDLE.
// Ports:
//   clk, rst_n          : clock, async active-low reset (already deassert-synchronised)
//   mas_alu_req         : level request, held high for back-to-back operations
//   mas_alu_fsm_state   : current state (debug / checker visibility)
//   mas_alu_fsm_oper    : high while in OPER (result is captured on the edge leaving it)
//   mas_alu_fsm_ready   : high while in DONE
module mas_alu_fsm
  import mas_alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mas_alu_req,
  output mas_alu_fsm_state_t mas_alu_fsm_state,
  output logic               mas_alu_fsm_oper,
  output logic               mas_alu_fsm_ready
);

  mas_alu_fsm_state_t state_q;
  mas_alu_fsm_state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MAS_ALU_FSM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAS_ALU_FSM_IDLE: state_d = mas_alu_req ? MAS_ALU_FSM_OPER : MAS_ALU_FSM_IDLE;
      MAS_ALU_FSM_OPER: state_d = MAS_ALU_FSM_DONE;
      MAS_ALU_FSM_DONE: state_d = mas_alu_req ? MAS_ALU_FSM_OPER : MAS_ALU_FSM_IDLE;
      default:          state_d = MAS_ALU_FSM_IDLE;
    endcase
  end

  assign mas_alu_fsm_state = state_q;
  assign mas_alu_fsm_oper  = (state_q == MAS_ALU_FSM_OPER);
  assign mas_alu_fsm_ready = (state_q == MAS_ALU_FSM_DONE);

endmodule

// File: rtl/mas_alu_top.sv
// mas_alu_top: multi-cycle integer ALU (add, sub, right shift, left shift).
// Handshake: mas_alu_req is a level; when sampled high the FSM enters OPER, and on
//   the following edge cmd/op1/op2 are sampled, the result is registered into
//   mas_alu_res and mas_alu_ready is high for exactly one cycle (the DONE cycle).
//   mas_alu_res then holds until the next completed operation.
// Ports:
//   clk, rst_n    : clock, async active-low reset (deassertion synchronised here)
//   mas_alu_req   : request level
//   mas_alu_cmd   : operation select
//   mas_alu_op1   : first operand / shift source
//   mas_alu_op2   : second operand / full-width shift amount
//   mas_alu_res   : registered result
//   mas_alu_ready : one-cycle result-valid pulse
// Build option: define MAS_ALU_ARITH_SHIFT_EN to make MAS_ALU_RSHIFT arithmetic
//   (sign-replicating); by default it is a logical zero-fill shift.
module mas_alu_top
  import mas_alu_pkg::*;
#(
  parameter int MAS_BLEN = MAS_ALU_BLEN_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mas_alu_req,
  input  type_mas_alu_cmd     mas_alu_cmd,
  input  logic [MAS_BLEN-1:0] mas_alu_op1,
  input  logic [MAS_BLEN-1:0] mas_alu_op2,
  output logic [MAS_BLEN-1:0] mas_alu_res,
  output logic                mas_alu_ready
);

  // Reset: asserts asynchronously, releases two clocks after rst_n rises.
  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;

  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  mas_alu_fsm_state_t fsm_state;
  logic               fsm_oper;
  logic               fsm_ready;

  mas_alu_fsm mfsm (
    .clk               (clk),
    .rst_n             (rst_sync_q),
    .mas_alu_req       (mas_alu_req),
    .mas_alu_fsm_state (fsm_state),
    .mas_alu_fsm_oper  (fsm_oper),
    .mas_alu_fsm_ready (fsm_ready)
  );

  // Datapath. The whole op2 is the shift amount, so any amount >= MAS_BLEN
  // shifts everything out; it is handled explicitly rather than relying on
  // the operator's out-of-range behaviour.
  logic [MAS_BLEN-1:0] result;
  logic                shift_oob;

  always_comb begin
    result    = '0;
    shift_oob = (mas_alu_op2 >= MAS_BLEN'(MAS_BLEN));
    case (mas_alu_cmd)
      MAS_ALU_ADD: result = mas_alu_op1 + mas_alu_op2;
      MAS_ALU_SUB: result = mas_alu_op1 - mas_alu_op2;
      MAS_ALU_RSHIFT: begin
`ifdef MAS_ALU_ARITH_SHIFT_EN
        result = shift_oob ? {MAS_BLEN{mas_alu_op1[MAS_BLEN-1]}}
                           : MAS_BLEN'($signed(mas_alu_op1) >>> mas_alu_op2);
`else
        result = shift_oob ? '0 : (mas_alu_op1 >> mas_alu_op2);
`endif
      end
      MAS_ALU_LSHIFT: result = shift_oob ? '0 : (mas_alu_op1 << mas_alu_op2);
      default:        result = '0;
    endcase
  end

  // Output registers: capture on the OPER->DONE edge, so ready is high
  // exactly during DONE and res holds otherwise.
  logic [MAS_BLEN-1:0] res_q, res_d;
  logic                ready_q, ready_d;

  always_comb begin
    res_d   = fsm_oper ? result : res_q;
    ready_d = fsm_oper;
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      res_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      ready_q <= ready_d;
    end
  end

  assign mas_alu_res   = res_q;
  assign mas_alu_ready = ready_q;

  a_ready_is_done: assert property (@(posedge clk) disable iff (!rst_sync_q)
    (mas_alu_ready == fsm_ready) && (fsm_ready == (fsm_state == MAS_ALU_FSM_DONE)));

endmodule

// File: tb/tb_mas_alu_top.sv
module tb_mas_alu_top;
  import mas_alu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            req;
  type_mas_alu_cmd cmd;
  logic [W-1:0]    op1, op2;
  logic [W-1:0]    res;
  logic            ready;

  mas_alu_top #(.MAS_BLEN(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mas_alu_req   (req),
    .mas_alu_cmd   (cmd),
    .mas_alu_op1   (op1),
    .mas_alu_op2   (op2),
    .mas_alu_res   (res),
    .mas_alu_ready (ready)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions (mod 2^32, floor division).
  function automatic logic [W-1:0] ref_alu(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned m  = 64'h1_0000_0000;
    longint unsigned la = 64'(a);
    longint unsigned lb = 64'(b);
    longint unsigned p  = 64'd1 << ((lb > 32) ? 32 : lb);
    longint          sa;
    longint          q;
    case (c)
      0: return W'((la + lb) % m);
      1: return W'((la + m - lb) % m);
      2: begin
`ifdef MAS_ALU_ARITH_SHIFT_EN
        sa = a[W-1] ? (longint'(la) - longint'(m)) : longint'(la);
        q  = (sa >= 0) ? (sa / longint'(p)) : ((sa - longint'(p) + 1) / longint'(p));
        return W'((q + longint'(m)) % longint'(m));
`else
        return W'(la / p);
`endif
      end
      default: return (lb >= 32) ? '0 : W'((la * p) % m);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
    cmd = type_mas_alu_cmd'(c);
    op1 = a;
    op2 = b;
    exp_q.push_back(ref_alu(c, a, b));
  endtask

  // Single operation; req drops during OPER, so the FSM returns to IDLE after DONE.
  task automatic do_op(input string tag, input int c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] e;
    @(negedge clk);
    req = 1'b1;
    drive_op(c, a, b);
    @(negedge clk);
    chk({tag, "_ready_oper"}, W'(ready), '0);
    req = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, "_ready"}, W'(ready), 1);
    chk({tag, "_res"}, res, e);
    @(negedge clk);
    chk({tag, "_ready_drop"}, W'(ready), '0);
    @(negedge clk);
    chk({tag, "_idle_ready"}, W'(ready), '0);
    chk({tag, "_res_hold"}, res, e);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic [W-1:0] rand_b;

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    cmd   = MAS_ALU_ADD;
    op1   = '0;
    op2   = '0;
    repeat (2) @(negedge clk);
    chk("reset_res", res, '0);
    chk("reset_ready", W'(ready), '0);
    release_reset();

    // Directed cases
    do_op("add_wrap", 0, 32'hFFFF_FFFF, 32'd2);
    do_op("sub_neg", 1, 32'd5, 32'd7);
    do_op("rsh_msb4", 2, 32'h8000_0000, 32'd4);
    do_op("lsh_31", 3, 32'd1, 32'd31);
    do_op("lsh_32", 3, 32'd1, 32'd32);
    do_op("rsh_40", 2, 32'hFFFF_FFFF, 32'd40);
    do_op("rsh_pos7", 2, 32'h7000_0001, 32'd7);
    do_op("add_basic", 0, 32'h1234_5678, 32'h1111_1111);

    // Reset in the middle of OPER: clears immediately, no result emerges.
    @(negedge clk);
    req = 1'b1;
    cmd = MAS_ALU_ADD; op1 = 32'd10; op2 = 32'd20;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_oper_res", res, '0);
    chk("rst_oper_ready", W'(ready), '0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_abort_ready", W'(ready), '0);
    end
    do_op("post_reset", 1, 32'd100, 32'd1);

    // Reset while the ready pulse is up.
    @(negedge clk);
    req = 1'b1;
    drive_op(0, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    chk("done_ready", W'(ready), 1);
    chk("done_res", res, exp_q.pop_front());
    rst_n = 1'b0;
    #1;
    chk("rst_done_ready", W'(ready), '0);
    chk("rst_done_res", res, '0);
    req = 1'b0;
    @(negedge clk);
    release_reset();

    // Back-to-back: req held high, new random ops presented in each DONE cycle.
    @(negedge clk);
    req = 1'b1;
    rand_b = $urandom_range(0, 1) ? W'($urandom_range(0, 40)) : W'($urandom);
    drive_op($urandom_range(0, 3), W'($urandom), rand_b);
    @(negedge clk);
    chk("b2b_first_oper", W'(ready), '0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("b2b_ready_hi", W'(ready), 1);
      chk("b2b_res", res, exp_q.pop_front());
      if (i < 39) begin
        rand_b = $urandom_range(0, 1) ? W'($urandom_range(0, 40)) : W'($urandom);
        drive_op($urandom_range(0, 3), W'($urandom), rand_b);
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      chk("b2b_ready_lo", W'(ready), '0);
    end
    @(negedge clk);
    chk("b2b_idle_ready", W'(ready), '0);
    chk("scoreboard_empty", W'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
